// File: rtl/alu_pkg.sv
// alu_pkg: opcode fields and mnemonics shared by the ALU and its result stage
package alu_pkg;
  typedef enum logic [2:0] {OTH, AND, ORR, ADD, SUB, CMP, XOR, FIRST} op_mne;
  typedef enum logic [1:0] {INC, NOT, LSR, LSL} op_oth;
  localparam int OP_MNE_HI = 4;
  localparam int OP_MNE_LO = 2;
  localparam int OP_SUB_HI = 1;
  localparam int OP_MODE_BIT = 5;
  function automatic logic is_cmp(input logic [5:0] op);
    return op_mne'(op[OP_MNE_HI:OP_MNE_LO]) == CMP;
  endfunction
endpackage

// File: rtl/result_fifo.sv
// result_fifo: small power-of-two FIFO whose head output holds the last popped entry when empty
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 11
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic [W-1:0] i_data,
  input  logic i_pop,
  output logic [W-1:0] o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0] r_cnt;
  logic [AW-1:0] w_head;
  assign o_count = r_cnt;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  // When empty, the slot just behind the read pointer still holds the last popped entry
  assign w_head = o_empty ? r_rd - 1'b1 : r_rd;
  assign o_data = r_mem[w_head];
  // Storage, pointers and occupancy; callers never push when full or pop when empty
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: buffers ALU results for writeback and tracks compare flags and issue stalls
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int REG_AW = 3,
  parameter int CNT_W = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic InValid,
  output logic InReady,
  input  logic [5:0] OP,
  input  logic [7:0] InputA,
  input  logic [7:0] InputB,
  input  logic [7:0] AluOut,
  input  logic [REG_AW-1:0] DestReg,
  output logic WbValid,
  input  logic WbReady,
  output logic [7:0] WbData,
  output logic [REG_AW-1:0] WbReg,
  output logic EqFlag,
  output logic LtFlag,
  output logic [CNT_W-1:0] StallCnt
);
  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_cmp;
  logic w_push;
  logic w_pop;
  logic [8+REG_AW-1:0] w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic w_unused;
  logic r_eq;
  logic r_lt;
  logic [CNT_W-1:0] r_stall;
  assign InReady = !w_full;
  assign WbValid = !w_empty;
  assign w_accept = InValid && InReady;
  assign w_cmp = is_cmp(OP);
  assign w_push = w_accept && !w_cmp;
  assign w_pop = WbValid && WbReady;
  assign {WbData, WbReg} = w_head;
  assign EqFlag = r_eq;
  assign LtFlag = r_lt;
  assign StallCnt = r_stall;
  assign w_unused = ^{OP[OP_MODE_BIT], OP[OP_SUB_HI:0], w_count};
  result_fifo #(.DEPTH(DEPTH), .W(8 + REG_AW)) u_fifo (
    .i_clk(Clk),
    .i_rst(Reset),
    .i_push(w_push),
    .i_data({AluOut, DestReg}),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_count(w_count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  // Compare flags change only on an accepted CMP
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_eq <= 1'b0;
      r_lt <= 1'b0;
    end else if (w_accept && w_cmp) begin
      r_eq <= AluOut == 8'h00;
      r_lt <= InputB < InputA;
    end
  end
  // Saturating count of cycles the issue side was held off
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_stall <= '0;
    else if (InValid && !InReady && r_stall != '1) r_stall <= r_stall + 1'b1;
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: randomized and directed checks against a queue-based reference model
module tb_alu_result_stage;
  localparam int DEPTH = 2;
  localparam logic [5:0] OP_ADD = 6'b0_011_00;
  localparam logic [5:0] OP_CMP = 6'b0_101_00;
  logic Clk = 0;
  logic Reset = 1;
  logic InValid = 0;
  logic InReady;
  logic [5:0] OP = '0;
  logic [7:0] InputA = '0;
  logic [7:0] InputB = '0;
  logic [7:0] AluOut = '0;
  logic [2:0] DestReg = '0;
  logic WbValid;
  logic WbReady = 0;
  logic [7:0] WbData;
  logic [2:0] WbReg;
  logic EqFlag;
  logic LtFlag;
  logic [7:0] StallCnt;
  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] q[$];
  logic m_eq = 0;
  logic m_lt = 0;
  int m_stall = 0;

  alu_result_stage #(.DEPTH(DEPTH), .REG_AW(3), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .OP(OP),
    .InputA(InputA), .InputB(InputB), .AluOut(AluOut), .DestReg(DestReg),
    .WbValid(WbValid), .WbReady(WbReady), .WbData(WbData), .WbReg(WbReg),
    .EqFlag(EqFlag), .LtFlag(LtFlag), .StallCnt(StallCnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("wb_valid", 32'(WbValid), 32'(q.size() > 0));
    chk("in_ready", 32'(InReady), 32'(q.size() != DEPTH));
    chk("eq_flag", 32'(EqFlag), 32'(m_eq));
    chk("lt_flag", 32'(LtFlag), 32'(m_lt));
    chk("stall_cnt", 32'(StallCnt), 32'(m_stall));
    if (q.size() > 0) begin
      chk("wb_data", 32'(WbData), 32'(q[0][10:3]));
      chk("wb_reg", 32'(WbReg), 32'(q[0][2:0]));
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_eq = 0;
    m_lt = 0;
    m_stall = 0;
  endtask

  task automatic cyc(input logic inv, input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] o, input logic [2:0] d, input logic wbr);
    logic rdy;
    logic acc;
    @(negedge Clk);
    check_outputs();
    InValid = inv; OP = op; InputA = a; InputB = b; AluOut = o; DestReg = d; WbReady = wbr;
    rdy = q.size() != DEPTH;
    acc = inv && rdy;
    if (inv && !rdy && m_stall < 255) m_stall++;
    if (q.size() > 0 && wbr) void'(q.pop_front());
    if (acc) begin
      if (op[4:2] == 3'b101) begin
        m_eq = o == 8'h00;
        m_lt = b < a;
      end else q.push_back({o, d});
    end
    @(posedge Clk);
  endtask

  task automatic idle(input logic wbr);
    cyc(0, '0, '0, '0, '0, '0, wbr);
  endtask

  initial begin
    logic [2:0] mne;
    logic [7:0] a;
    logic [7:0] b;
    repeat (2) @(posedge Clk);
    #2;
    chk("rst_valid", 32'(WbValid), 0);
    chk("rst_data", 32'(WbData), 0);
    @(negedge Clk);
    Reset = 0;
    model_reset();
    cyc(1, OP_ADD, 8'h01, 8'h02, 8'h3C, 3'd3, 1);
    #2;
    chk("add_valid", 32'(WbValid), 1);
    chk("add_data", 32'(WbData), 32'h3C);
    chk("add_reg", 32'(WbReg), 3);
    idle(1);
    #2;
    chk("add_drained", 32'(WbValid), 0);
    cyc(1, OP_ADD, 0, 0, 8'h11, 3'd1, 0);
    cyc(1, OP_ADD, 0, 0, 8'h22, 3'd2, 0);
    cyc(1, OP_ADD, 0, 0, 8'h33, 3'd3, 0);
    cyc(1, OP_ADD, 0, 0, 8'h33, 3'd3, 0);
    #2;
    chk("bp_stall", 32'(StallCnt), 2);
    for (int i = 0; i < 4; i++) cyc(1, OP_ADD, 0, 0, 8'h33, 3'd3, 1);
    repeat (3) idle(1);
    cyc(1, OP_CMP, 8'h05, 8'h05, 8'h00, 3'd0, 1);
    #2;
    chk("cmp_eq", 32'({EqFlag, LtFlag}), 32'b10);
    chk("cmp_nopush", 32'(WbValid), 0);
    cyc(1, OP_CMP, 8'h07, 8'h02, 8'h05, 3'd0, 1);
    #2;
    chk("cmp_lt", 32'({EqFlag, LtFlag}), 32'b01);
    cyc(1, OP_ADD, 8'h00, 8'h00, 8'h00, 3'd4, 1);
    idle(1);
    for (int w = 0; w < 4 * DEPTH; w++) begin
      idle(0);
      cyc(1, OP_ADD, 0, 0, 8'(8'h40 + 2 * w), 3'(w), 0);
      cyc(1, OP_ADD, 0, 0, 8'(8'h41 + 2 * w), 3'(w + 1), 0);
      cyc(1, OP_ADD, 0, 0, 8'(8'hA0 + w), 3'(w), 1);
      cyc(1, OP_ADD, 0, 0, 8'(8'hA0 + w), 3'(w), 1);
      repeat (2) idle(1);
    end
    cyc(1, OP_ADD, 0, 0, 8'h55, 3'd5, 0);
    cyc(1, OP_ADD, 0, 0, 8'h66, 3'd6, 0);
    idle(0);
    #3;
    Reset = 1;
    #1;
    chk("arst_valid", 32'(WbValid), 0);
    chk("arst_flags", 32'({EqFlag, LtFlag}), 0);
    chk("arst_stall", 32'(StallCnt), 0);
    chk("arst_data", 32'(WbData), 0);
    model_reset();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 0;
    for (int i = 0; i < 600; i++) begin
      mne = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      cyc($urandom_range(0, 3) != 0, {1'($urandom), mne, 2'($urandom)}, a, b,
          mne == 3'b101 ? 8'(a - b) : 8'($urandom), 3'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 302; i++) cyc(1, OP_ADD, 0, 0, 8'(i), 3'(i), 0);
    #2;
    chk("stall_sat", 32'(StallCnt), 32'hFF);
    repeat (5) cyc(1, OP_ADD, 0, 0, 8'h77, 3'd7, 0);
    idle(1);
    #2;
    chk("stall_hold", 32'(StallCnt), 32'hFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
